load_writeback: RTL and testbench

LOAD_WRITEBACK -- requirements
Module: load_writeback

---
 rtl/load_pkg.sv | 62 ++++++
 rtl/regfile_2r1w.sv | 38 +++
 rtl/load_writeback.sv | 158 +++++++++++++++
 tb/tb_load_writeback.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_pkg
// Description : Shared load-stage definitions: data width, funct3 load
//               encodings, error cause codes and the decode helpers used by
//               the load writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package load_pkg;

  localparam int XLEN = 64;

  // funct3 load encodings
  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LD  = 3'b011;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;
  localparam logic [2:0] c_F3_LWU = 3'b110;
  localparam logic [2:0] c_F3_ILL = 3'b111;

  // Error cause codes
  localparam logic [1:0] c_ERR_NONE     = 2'b00;
  localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] c_ERR_ILLEGAL  = 2'b11;

  // Classify an access: illegal encoding, misaligned for its size, or fine.
  function automatic logic [1:0] load_check(input logic [2:0] ofs, input logic [2:0] f3);
    logic [1:0] cause;
    cause = c_ERR_NONE;
    case (f3)
      c_F3_LH, c_F3_LHU: if (ofs[0] != 1'b0) cause = c_ERR_MISALIGN;
      c_F3_LW, c_F3_LWU: if (ofs[1:0] != 2'b00) cause = c_ERR_MISALIGN;
      c_F3_LD:           if (ofs != 3'b000) cause = c_ERR_MISALIGN;
      c_F3_ILL:          cause = c_ERR_ILLEGAL;
      default:           cause = c_ERR_NONE;
    endcase
    return cause;
  endfunction

  // Pick the addressed bytes out of the doubleword and sign/zero extend.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] data,
                                                  input logic [2:0]      ofs,
                                                  input logic [2:0]      f3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = data >> {ofs, 3'b000};
    case (f3)
      c_F3_LB:  res = {{(XLEN-8){sh[7]}},   sh[7:0]};
      c_F3_LH:  res = {{(XLEN-16){sh[15]}}, sh[15:0]};
      c_F3_LW:  res = {{(XLEN-32){sh[31]}}, sh[31:0]};
      c_F3_LBU: res = {{(XLEN-8){1'b0}},    sh[7:0]};
      c_F3_LHU: res = {{(XLEN-16){1'b0}},   sh[15:0]};
      c_F3_LWU: res = {{(XLEN-32){1'b0}},   sh[31:0]};
      default:  res = sh;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : Integer register file, two combinational read ports and one
//               write port; register 0 reads as zero and ignores writes.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] r_regs [NREG];

  // Register array update; x0 is never written so it stays at its reset zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : r_regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : r_regs[raddr2];

endmodule
`default_nettype wire

// File: rtl/load_writeback.sv
`default_nettype none
// ============================================================================
// Module      : load_writeback
// Description : Load alignment/extension stage with a one-entry S1 holding
//               register, error reporting and register file writeback. The
//               ALU writeback port has priority and stalls pending loads.
//               Option macro LOAD_WB_BYPASS_EN: forward ALU/S1 data onto the
//               read ports; when undefined a stage_busy output is present.
// Revision    : 1.0 - initial release
// ============================================================================
module load_writeback #(
  parameter int XLEN = load_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [2:0]      ld_funct3,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ext_we,
  input  logic [4:0]      ext_rd,
  input  logic [XLEN-1:0] ext_wdata,
  input  logic [4:0]      r1,
  input  logic [4:0]      r2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            ld_err,
  output logic [1:0]      err_cause,
  output logic [31:0]     load_count
`ifndef LOAD_WB_BYPASS_EN
  ,output logic           stage_busy
`endif
);

  import load_pkg::*;

  logic            r_s1_valid;
  logic            r_s1_err;
  logic [1:0]      r_s1_cause;
  logic [4:0]      r_s1_rd;
  logic [XLEN-1:0] r_s1_data;

  logic            w_ext_hit;
  logic            w_s1_commit;
  logic            w_accept;
  logic [1:0]      w_cause;
  logic [XLEN-1:0] w_ext_val;
  logic            w_rf_we;
  logic [4:0]      w_rf_waddr;
  logic [XLEN-1:0] w_rf_wdata;
  logic [XLEN-1:0] w_rf_rd1;
  logic [XLEN-1:0] w_rf_rd2;
  logic            w_unused_addr;

  // An ALU write to x0 is a no-op, so it must not hold back the load.
  assign w_ext_hit   = ext_we && (ext_rd != 5'd0);
  assign w_s1_commit = r_s1_valid && !w_ext_hit;
  assign ld_ready    = !r_s1_valid || w_s1_commit;
  assign w_accept    = ld_valid && ld_ready;

  assign w_cause       = load_check(ld_addr[2:0], ld_funct3);
  assign w_ext_val     = load_extend(ld_data, ld_addr[2:0], ld_funct3);
  assign w_unused_addr = ^ld_addr[XLEN-1:3];

  // S1 holding register: refill on accept, drain on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_cause <= c_ERR_NONE;
      r_s1_rd    <= 5'd0;
      r_s1_data  <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_err   <= (w_cause != c_ERR_NONE);
      r_s1_cause <= w_cause;
      r_s1_rd    <= ld_rd;
      r_s1_data  <= w_ext_val;
    end else if (w_s1_commit) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Commit side effects: writeback/error pulses, sticky cause, load counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      ld_err     <= 1'b0;
      err_cause  <= c_ERR_NONE;
      load_count <= 32'd0;
    end else begin
      wb_valid <= w_s1_commit && !r_s1_err;
      ld_err   <= w_s1_commit && r_s1_err;
      if (w_s1_commit && !r_s1_err) begin
        wb_rd      <= r_s1_rd;
        wb_data    <= r_s1_data;
        load_count <= load_count + 32'd1;
      end
      if (w_s1_commit && r_s1_err) begin
        err_cause <= r_s1_cause;
      end
    end
  end

  // Single write port: the ALU result wins, otherwise an error-free load.
  assign w_rf_we    = w_ext_hit || (w_s1_commit && !r_s1_err);
  assign w_rf_waddr = w_ext_hit ? ext_rd : r_s1_rd;
  assign w_rf_wdata = w_ext_hit ? ext_wdata : r_s1_data;

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (w_rf_we),
    .waddr  (w_rf_waddr),
    .wdata  (w_rf_wdata),
    .raddr1 (r1),
    .raddr2 (r2),
    .rdata1 (w_rf_rd1),
    .rdata2 (w_rf_rd2)
  );

`ifdef LOAD_WB_BYPASS_EN
  // Forward in-flight values: same-cycle ALU write first, then the S1 load.
  always_comb begin
    rs1_data = w_rf_rd1;
    rs2_data = w_rf_rd2;
    if (r1 != 5'd0) begin
      if (ext_we && (ext_rd == r1))
        rs1_data = ext_wdata;
      else if (r_s1_valid && !r_s1_err && (r_s1_rd == r1))
        rs1_data = r_s1_data;
    end
    if (r2 != 5'd0) begin
      if (ext_we && (ext_rd == r2))
        rs2_data = ext_wdata;
      else if (r_s1_valid && !r_s1_err && (r_s1_rd == r2))
        rs2_data = r_s1_data;
    end
  end
`else
  assign rs1_data   = w_rf_rd1;
  assign rs2_data   = w_rf_rd2;
  assign stage_busy = r_s1_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_writeback
// Description : Directed self-checking bench for load_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_writeback;
  import load_pkg::*;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [63:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [63:0] ld_data;
  logic        ext_we;
  logic [4:0]  ext_rd;
  logic [63:0] ext_wdata;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ld_err;
  logic [1:0]  err_cause;
  logic [31:0] load_count;
`ifndef LOAD_WB_BYPASS_EN
  logic        stage_busy;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  load_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_addr    (ld_addr),
    .ld_funct3  (ld_funct3),
    .ld_data    (ld_data),
    .ext_we     (ext_we),
    .ext_rd     (ext_rd),
    .ext_wdata  (ext_wdata),
    .r1         (r1),
    .r2         (r2),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ld_err     (ld_err),
    .err_cause  (err_cause),
    .load_count (load_count)
`ifndef LOAD_WB_BYPASS_EN
    ,.stage_busy (stage_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [63:0] addr,
                       input logic [2:0] f3, input logic [63:0] data);
    ld_valid  = 1'b1;
    ld_rd     = rd;
    ld_addr   = addr;
    ld_funct3 = f3;
    ld_data   = data;
    step();
    ld_valid  = 1'b0;
  endtask

  task automatic reg_is(input string tag, input logic [4:0] idx, input logic [63:0] exp);
    r1 = idx;
    r2 = idx;
    #1;
    check({tag, "_rs1"}, rs1_data, exp);
    check({tag, "_rs2"}, rs2_data, exp);
  endtask

  task automatic load_ok(input string tag, input logic [4:0] rd, input logic [63:0] addr,
                         input logic [2:0] f3, input logic [63:0] data, input logic [63:0] exp);
    issue(rd, addr, f3, data);
    step();
    exp_cnt++;
    check({tag, "_wbv"}, wb_valid, 1);
    check({tag, "_wbrd"}, wb_rd, rd);
    check({tag, "_wbdata"}, wb_data, exp);
    check({tag, "_cnt"}, load_count, exp_cnt);
    if (rd != 5'd0) reg_is(tag, rd, exp);
  endtask

  task automatic load_bad(input string tag, input logic [4:0] rd, input logic [63:0] addr,
                          input logic [2:0] f3, input logic [1:0] cause);
    issue(rd, addr, f3, 64'h0123_4567_89AB_CDEF);
    step();
    check({tag, "_err"}, ld_err, 1);
    check({tag, "_cause"}, err_cause, cause);
    check({tag, "_wbv"}, wb_valid, 0);
    check({tag, "_cnt"}, load_count, exp_cnt);
    step();
    check({tag, "_errpulse"}, ld_err, 0);
    check({tag, "_causehold"}, err_cause, cause);
  endtask

  initial begin
    rst = 1'b0; ld_valid = 1'b0; ld_rd = 5'd0; ld_addr = '0; ld_funct3 = 3'd0;
    ld_data = '0; ext_we = 1'b0; ext_rd = 5'd0; ext_wdata = '0; r1 = 5'd0; r2 = 5'd0;
    #1 rst = 1'b1;
    #2;
    check("rst_ready", ld_ready, 1);
    check("rst_wbv", wb_valid, 0);
    check("rst_err", ld_err, 0);
    check("rst_cause", err_cause, 0);
    check("rst_cnt", load_count, 0);
    // A load offered during reset must be ignored
    ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = c_F3_LD; ld_data = 64'h55;
    step();
    check("rst_ready_held", ld_ready, 1);
    step();
    ld_valid = 1'b0;
    rst = 1'b0;
    step();
    check("post_rst_wbv", wb_valid, 0);
    reg_is("post_rst_x4", 5'd4, 64'h0);

    // Extension and alignment cases
    load_ok("lb",   5'd1,  64'h0, c_F3_LB,  64'h0000_0000_0000_80FF, 64'hFFFF_FFFF_FFFF_FFFF);
    load_ok("lbu",  5'd2,  64'h0, c_F3_LBU, 64'h0000_0000_0000_80FF, 64'h0000_0000_0000_00FF);
    load_ok("lh",   5'd3,  64'h0, c_F3_LH,  64'h0000_0000_0000_80FF, 64'hFFFF_FFFF_FFFF_80FF);
    load_ok("lw",   5'd5,  64'h4, c_F3_LW,  64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
    load_ok("lwu",  5'd8,  64'h4, c_F3_LWU, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
    load_ok("ld",   5'd9,  64'h0, c_F3_LD,  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    load_ok("lhu",  5'd10, 64'h6, c_F3_LHU, 64'h8000_0001_0000_0000, 64'h0000_0000_0000_8000);
    load_ok("lb7",  5'd11, 64'h7, c_F3_LB,  64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F);

    // Errors
    load_bad("lh_mis", 5'd5, 64'h3, c_F3_LH, c_ERR_MISALIGN);
    reg_is("lh_mis_x5", 5'd5, 64'hFFFF_FFFF_8000_0001);
    load_bad("illegal", 5'd5, 64'h0, c_F3_ILL, c_ERR_ILLEGAL);
    load_bad("ld_mis", 5'd9, 64'h4, c_F3_LD, c_ERR_MISALIGN);
    reg_is("ld_mis_x9", 5'd9, 64'h1234_5678_9ABC_DEF0);
    load_ok("lh_a2", 5'd12, 64'h2, c_F3_LH, 64'h0000_0000_1234_0000, 64'h0000_0000_0000_1234);
    check("cause_sticky", err_cause, c_ERR_MISALIGN);

    // Stall: ALU writes x6 for 3 cycles while a load to x7 waits
    issue(5'd7, 64'h0, c_F3_LD, 64'h1111_2222_3333_4444);
    ext_we = 1'b1; ext_rd = 5'd6; ext_wdata = 64'hAAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", ld_ready, 0);
      check("stall_wbv", wb_valid, 0);
      step();
    end
    ext_we = 1'b0;
    #1;
    check("stall_release", ld_ready, 1);
    step();
    exp_cnt++;
    check("stall_wbv_after", wb_valid, 1);
    check("stall_wbrd", wb_rd, 7);
    check("stall_cnt", load_count, exp_cnt);
    reg_is("stall_x7", 5'd7, 64'h1111_2222_3333_4444);
    reg_is("stall_x6", 5'd6, 64'hAAAA);

    // Same destination: ALU value lands first, load overwrites afterwards
    issue(5'd6, 64'h0, c_F3_LD, 64'h5555);
    ext_we = 1'b1; ext_rd = 5'd6; ext_wdata = 64'hBBBB;
    step();
    ext_we = 1'b0;
`ifdef LOAD_WB_BYPASS_EN
    reg_is("same_mid", 5'd6, 64'h5555);
`else
    reg_is("same_mid", 5'd6, 64'hBBBB);
`endif
    step();
    exp_cnt++;
    check("same_wbv", wb_valid, 1);
    reg_is("same_final", 5'd6, 64'h5555);

    // Read port while the load still sits in S1
    issue(5'd2, 64'h0, c_F3_LW, 64'h0000_0000_1234_5678);
    r1 = 5'd2;
    #1;
`ifdef LOAD_WB_BYPASS_EN
    check("s1_read", rs1_data, 64'h1234_5678);
`else
    check("s1_read", rs1_data, 64'hFF);
    check("s1_busy", stage_busy, 1);
`endif
    step();
    exp_cnt++;
    reg_is("s1_commit", 5'd2, 64'h1234_5678);

    // Load to x0 alongside an ALU write to x0: no stall, wb still pulses
    ext_we = 1'b1; ext_rd = 5'd0; ext_wdata = 64'h99;
    issue(5'd0, 64'h0, c_F3_LD, 64'hDEAD);
    check("x0_ready", ld_ready, 1);
    step();
    ext_we = 1'b0;
    exp_cnt++;
    check("x0_wbv", wb_valid, 1);
    check("x0_wbrd", wb_rd, 0);
    check("x0_wbdata", wb_data, 64'hDEAD);
    reg_is("x0", 5'd0, 64'h0);

    // Back-to-back loads, one per cycle
    ld_valid = 1'b1; ld_rd = 5'd13; ld_addr = '0; ld_funct3 = c_F3_LD; ld_data = 64'hA1;
    step();
    ld_rd = 5'd14; ld_data = 64'hB2;
    #1;
    check("b2b_ready", ld_ready, 1);
    step();
    ld_valid = 1'b0;
    check("b2b_wb1", wb_rd, 13);
    check("b2b_data1", wb_data, 64'hA1);
    step();
    exp_cnt += 2;
    check("b2b_wbv2", wb_valid, 1);
    check("b2b_wb2", wb_rd, 14);
    check("b2b_cnt", load_count, exp_cnt);
    step();
    check("b2b_idle", wb_valid, 0);

    // Reset asserted while a load is stalled in S1
    issue(5'd12, 64'h0, c_F3_LD, 64'h77);
    ext_we = 1'b1; ext_rd = 5'd13; ext_wdata = 64'h66;
    step();
    r1 = 5'd5; r2 = 5'd5;
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", ld_ready, 1);
    check("arst_wbv", wb_valid, 0);
    check("arst_cause", err_cause, 0);
    check("arst_cnt", load_count, 0);
    check("arst_wbdata", wb_data, 0);
    check("arst_x5", rs1_data, 0);
`ifndef LOAD_WB_BYPASS_EN
    check("arst_busy", stage_busy, 0);
`endif
    ext_we = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("arst_nowb", wb_valid, 0);
    reg_is("arst_x12", 5'd12, 64'h0);
    reg_is("arst_x13", 5'd13, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
